// File: rtl/clock_time_keeper.sv
// ---------------------------------------------------------------------------
// clock_time_keeper
//   24 h BCD time keeper for the tube/LED display stage. A prescaler derives
//   a 1 Hz tick from clk. Two debounced push keys let the user set hours and
//   minutes of either the running time or the alarm. A registered flag
//   reports an alarm match and holds for one minute.
//
// Ports
//   clk          system clock
//   rst_n        synchronous, active-low reset
//   sw0          1 = auto run, 0 = manual set          (asynchronous switch)
//   sw1          set mode target: 1 = time, 0 = alarm  (asynchronous switch)
//   key_hour_n   raw hour key, active-low, bouncy
//   key_min_n    raw minute key, active-low, bouncy
//   secL..hourH  BCD display digits (alarm hh:mm:00 while setting the alarm)
//   tick_1hz     one-cycle pulse per second tick
//   alarm_hit    alarm match flag, held for 60 ticks
// ---------------------------------------------------------------------------
module clock_time_keeper #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw0,
  input  logic       sw1,
  input  logic       key_hour_n,
  input  logic       key_min_n,
  output logic [3:0] secL,
  output logic [3:0] secH,
  output logic [3:0] minL,
  output logic [3:0] minH,
  output logic [3:0] hourL,
  output logic [3:0] hourH,
  output logic       tick_1hz,
  output logic       alarm_hit
);

  localparam int PW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);

  // Two BCD digits: tens in h, units in l.
  typedef struct packed {
    logic [3:0] h;
    logic [3:0] l;
  } bcd2_t;

  // Increment a two-digit BCD value, wrapping to 00 after 'last'.
  function automatic bcd2_t inc_bcd(input bcd2_t v, input bcd2_t last);
    bcd2_t r;
    if (v == last) begin
      r = '0;
    end else if (v.l == 4'd9) begin
      r.h = v.h + 4'd1;
      r.l = 4'd0;
    end else begin
      r.h = v.h;
      r.l = v.l + 4'd1;
    end
    return r;
  endfunction

  // ---------------- input synchronisers ----------------
  logic [3:0] raw, meta, syncd;
  logic       sw0_s, sw1_s;
  logic [1:0] key_s;                 // [0] = hour, [1] = minute

  assign raw   = {key_min_n, key_hour_n, sw1, sw0};
  assign sw0_s = syncd[0];
  assign sw1_s = syncd[1];
  assign key_s = syncd[3:2];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others; blocking here would collapse the
  // two synchroniser stages into one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta  <= '1;
      syncd <= '1;
    end else begin
      meta  <= raw;
      syncd <= meta;
    end
  end

  // ---------------- debounce ----------------
  // The counter only runs while the synced level disagrees with the accepted
  // level, so any bounce back restarts the qualification window.
  logic [1:0]         key_stable;
  logic [1:0]         press;
  logic [1:0][DW-1:0] db_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_stable <= '1;
      press      <= '0;
      db_cnt     <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (key_s[i] == key_stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i]     <= '0;
          key_stable[i] <= key_s[i];
          // Accepted level flips; old level 1 means this is a 1->0 press.
          press[i]      <= key_stable[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  // ---------------- prescaler ----------------
  logic [PW-1:0] pre_cnt;

  assign tick_1hz = sw0_s && (pre_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || !sw0_s || tick_1hz) pre_cnt <= '0;
    else                              pre_cnt <= pre_cnt + PW'(1);
  end

  // ---------------- time and alarm registers ----------------
  bcd2_t sec_q, min_q, hour_q, al_min_q, al_hour_q;
  bcd2_t sec_nx, min_nx, hour_nx;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    sec_nx  = inc_bcd(sec_q, 8'h59);
    min_nx  = min_q;
    hour_nx = hour_q;
    if (sec_q == 8'h59) begin
      min_nx = inc_bcd(min_q, 8'h59);
      if (min_q == 8'h59) hour_nx = inc_bcd(hour_q, 8'h23);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sec_q     <= '0;
      min_q     <= '0;
      hour_q    <= '0;
      al_min_q  <= '0;
      al_hour_q <= '0;
    end else if (sw0_s) begin
      if (tick_1hz) begin
        sec_q  <= sec_nx;
        min_q  <= min_nx;
        hour_q <= hour_nx;
      end
    end else if (sw1_s) begin
      // Manual minute set never carries into hours; seconds stay as they are.
      if (press[1]) min_q  <= inc_bcd(min_q, 8'h59);
      if (press[0]) hour_q <= inc_bcd(hour_q, 8'h23);
    end else begin
      if (press[1]) al_min_q  <= inc_bcd(al_min_q, 8'h59);
      if (press[0]) al_hour_q <= inc_bcd(al_hour_q, 8'h23);
    end
  end

  // ---------------- alarm flag ----------------
  // Compare against the value the tick is about to load, so the flag rises
  // on the same edge the matching time appears.
  logic       match_nx;
  logic [5:0] hit_cnt;

  assign match_nx = (sec_nx == 8'h00) && (min_nx == al_min_q) &&
                    (hour_nx == al_hour_q);

  always_ff @(posedge clk) begin
    if (!rst_n || !sw0_s || (|press)) begin
      alarm_hit <= 1'b0;
      hit_cnt   <= '0;
    end else if (tick_1hz) begin
      if (match_nx) begin
        alarm_hit <= 1'b1;
        hit_cnt   <= '0;
      end else if (alarm_hit) begin
        if (hit_cnt == 6'd59) alarm_hit <= 1'b0;
        else                  hit_cnt   <= hit_cnt + 6'd1;
      end
    end
  end

  // ---------------- display select ----------------
  logic show_alarm;

  assign show_alarm = !sw0_s && !sw1_s;
  assign {hourH, hourL, minH, minL, secH, secL} =
      show_alarm ? {al_hour_q, al_min_q, 8'h00} : {hour_q, min_q, sec_q};

endmodule

// File: tb/tb_clock_time_keeper.sv
// ---------------------------------------------------------------------------
// tb_clock_time_keeper
//   Directed bench for clock_time_keeper with TICK_DIV=4, DB_CYCLES=3.
//   Stimulus pushes hand-computed expectations into a scoreboard queue; a
//   monitor on the falling edge pops each entry and compares it with the
//   observed {tick_1hz, alarm_hit, hh:mm:ss} vector under a mask.
// ---------------------------------------------------------------------------
module tb_clock_time_keeper;

  localparam int TICK_DIV  = 4;
  localparam int DB_CYCLES = 3;

  localparam logic [25:0] M_TIME = 26'h0FF_FFFF;
  localparam logic [25:0] M_HM   = 26'h0FF_FF00;
  localparam logic [25:0] M_HIT  = 26'h100_0000;
  localparam logic [25:0] M_TICK = 26'h200_0000;
  localparam logic [25:0] M_ALL  = M_TIME | M_HIT | M_TICK;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw0 = 1'b1;
  logic       sw1 = 1'b1;
  logic       key_hour_n = 1'b1;
  logic       key_min_n = 1'b1;
  logic [3:0] secL, secH, minL, minH, hourL, hourH;
  logic       tick_1hz, alarm_hit;

  clock_time_keeper #(
    .TICK_DIV (TICK_DIV),
    .DB_CYCLES(DB_CYCLES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw0       (sw0),
    .sw1       (sw1),
    .key_hour_n(key_hour_n),
    .key_min_n (key_min_n),
    .secL      (secL),
    .secH      (secH),
    .minL      (minL),
    .minH      (minH),
    .hourL     (hourL),
    .hourH     (hourH),
    .tick_1hz  (tick_1hz),
    .alarm_hit (alarm_hit)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  typedef struct {
    string       name;
    logic [25:0] exp;
    logic [25:0] mask;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        cur;
  logic [25:0] obs;
  int          n_cmp  = 0;
  int          n_fail = 0;

  function automatic logic [25:0] pack(int hh, int mm, int ss, logic tk, logic ht);
    return {tk, ht, 4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10),
            4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic check(input string name, input int hh, input int mm, input int ss,
                       input logic tk, input logic ht, input logic [25:0] mask);
    exp_t e;
    e.name = name;
    e.exp  = pack(hh, mm, ss, tk, ht);
    e.mask = mask;
    sb_q.push_back(e);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      obs = {tick_1hz, alarm_hit, hourH, hourL, minH, minL, secH, secL};
      n_cmp++;
      if ((obs & cur.mask) !== (cur.exp & cur.mask)) begin
        n_fail++;
        $display("FAIL %s: got %h, expected %h (mask %h)",
                 cur.name, obs & cur.mask, cur.exp & cur.mask, cur.mask);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  // which: 0 = hour key, 1 = minute key
  task automatic press(input int which, input int n);
    for (int i = 0; i < n; i++) begin
      if (which == 0) key_hour_n = 1'b0; else key_min_n = 1'b0;
      step(8);
      if (which == 0) key_hour_n = 1'b1; else key_min_n = 1'b1;
      step(8);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step(1);

    // 1. Reset, free run: tick every 4th cycle, 60 ticks -> 00:01:00.
    sw0 = 1'b1; sw1 = 1'b1;
    do_reset();
    for (int j = 0; j < 12; j++) begin
      check($sformatf("run_cycle%0d", j), 0, 0, j / 4, (j % 4) == 3, 1'b0, M_ALL);
      step(1);
    end
    step(228);
    check("run_60_ticks", 0, 1, 0, 1'b0, 1'b0, M_ALL);

    // 2. Preload 23:59:59, first tick a full second after returning to run.
    step(236);
    check("run_to_0159", 0, 1, 59, 1'b0, 1'b0, M_ALL);
    sw0 = 1'b0;
    press(0, 23);
    press(1, 58);
    check("preload_235959", 23, 59, 59, 1'b0, 1'b0, M_ALL);
    sw0 = 1'b1;
    step(5);
    check("first_tick_delay", 23, 59, 59, 1'b1, 1'b0, M_ALL);
    step(1);
    check("rollover_000000", 0, 0, 0, 1'b0, 1'b1, M_ALL);
    sw0 = 1'b0;
    step(3);
    check("sw0_clears_hit", 0, 0, 0, 1'b0, 1'b0, M_ALL);
    press(0, 9);
    press(1, 59);
    check("preload_095900", 9, 59, 0, 1'b0, 1'b0, M_ALL);
    sw0 = 1'b1;
    step(241);
    check("at_095959", 9, 59, 59, 1'b1, 1'b0, M_ALL);
    step(1);
    check("carry_to_100000", 10, 0, 0, 1'b0, 1'b0, M_ALL);

    // 3. Bouncy minute key -> exactly one increment; 59 -> 00 without hour carry.
    sw0 = 1'b0; sw1 = 1'b1;
    key_min_n = 1'b0; step(1);
    key_min_n = 1'b1; step(1);
    key_min_n = 1'b0; step(10);
    key_min_n = 1'b1; step(10);
    check("bounce_single_press", 10, 1, 0, 1'b0, 1'b0, M_ALL);
    press(1, 58);
    check("min_59", 10, 59, 0, 1'b0, 1'b0, M_ALL);
    press(1, 1);
    check("min_wrap_no_carry", 10, 0, 0, 1'b0, 1'b0, M_ALL);

    // 4. Alarm setting shows alarm hh:mm:00 and leaves time alone.
    sw1 = 1'b0;
    step(3);
    check("alarm_display_0000", 0, 0, 0, 1'b0, 1'b0, M_ALL);
    press(0, 7);
    press(1, 30);
    check("alarm_0730", 7, 30, 0, 1'b0, 1'b0, M_ALL);
    sw1 = 1'b1;
    step(3);
    check("time_untouched", 10, 0, 0, 1'b0, 1'b0, M_ALL);

    // 5. Alarm 00:01 with time 00:00:59: flag after tick, holds 60 ticks.
    sw0 = 1'b1;
    do_reset();
    step(236);
    check("t5_time_0059", 0, 0, 59, 1'b0, 1'b0, M_ALL);
    sw0 = 1'b0; sw1 = 1'b0;
    press(1, 1);
    check("t5_alarm_0001", 0, 1, 0, 1'b0, 1'b0, M_ALL);
    sw1 = 1'b1;
    sw0 = 1'b1;
    step(5);
    check("t5_tick_no_hit", 0, 0, 59, 1'b1, 1'b0, M_ALL);
    step(1);
    check("t5_hit_rises", 0, 1, 0, 1'b0, 1'b1, M_ALL);
    step(239);
    check("t5_hit_last_tick", 0, 1, 59, 1'b1, 1'b1, M_ALL);
    step(1);
    check("t5_hit_cleared", 0, 2, 0, 1'b0, 1'b0, M_ALL);
    sw0 = 1'b0; sw1 = 1'b0;
    press(1, 2);
    check("t5_alarm_0003", 0, 3, 0, 1'b0, 1'b0, M_ALL);
    sw1 = 1'b1;
    sw0 = 1'b1;
    step(242);
    check("t5_second_hit", 0, 3, 0, 1'b0, 1'b1, M_ALL);
    step(40);
    key_hour_n = 1'b0;
    step(8);
    check("t5_key_clears_hit", 0, 3, 0, 1'b0, 1'b0, M_HM | M_HIT);
    key_hour_n = 1'b1;
    step(8);

    // 6. One-cycle reset mid-debounce and mid-second.
    key_min_n = 1'b0;
    step(4);
    rst_n = 1'b0;
    key_min_n = 1'b1;
    step(1);
    rst_n = 1'b1;
    check("t6_after_reset", 0, 0, 0, 1'b0, 1'b0, M_ALL);
    sw0 = 1'b0; sw1 = 1'b1;
    step(20);
    check("t6_no_spurious_press", 0, 0, 0, 1'b0, 1'b0, M_ALL);
    sw1 = 1'b0;
    step(3);
    check("t6_alarm_reset", 0, 0, 0, 1'b0, 1'b0, M_ALL);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    step(1);
    if (sb_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
